// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states, lane-mask helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_e;

  // Byte lanes over two consecutive words: [3:0] first word, [7:4] second word.
  function automatic logic [7:0] lane_masks(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic funct3_ok(input logic store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extract-and-extend of an LSB-aligned assembled load word according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata_c
);

  always_comb begin
    rdata_c = data;
    case (funct3)
      F3_B:    rdata_c = {{24{data[7]}}, data[7:0]};
      F3_H:    rdata_c = {{16{data[15]}}, data[15:0]};
      F3_BU:   rdata_c = {24'd0, data[7:0]};
      F3_HU:   rdata_c = {16'd0, data[15:0]};
      default: rdata_c = data;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving the byte-banked data memory port; word-crossing accesses are split
// into two memory cycles unless MISALIGN_TRAP_EN is defined, in which case they are rejected.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  lsu_state_e  state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  req_mask_c;
  logic        req_bad_c;
  logic [31:0] st_lo_c;
  logic [31:0] ld_word_c;
  logic [31:0] ld_rdata_c;

  assign req_mask_c = lane_masks(req_funct3[1:0], req_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign req_bad_c = !funct3_ok(req_store, req_funct3) || (req_mask_c[7:4] != 4'd0);
  assign st_lo_c   = req_wdata << {req_addr[1:0], 3'b000};
  assign ld_word_c = drdata >> {off_q, 3'b000};
`else
  localparam logic [31:0] WIN_LO = 32'((64'd1 << DMEM_AW) - 64'd1);
  localparam logic [31:0] WIN    = WIN_LO & ~32'd3;

  logic [31:0] rbuf_q, next_addr_q, wdata_hi_q;
  logic [3:0]  mask_hi_q;
  logic [63:0] st_pair_c, ld_pair_c;
  logic [31:0] next_addr_c;

  assign req_bad_c   = !funct3_ok(req_store, req_funct3);
  assign st_pair_c   = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
  assign st_lo_c     = st_pair_c[31:0];
  // Second word: bits above the memory window kept, word index wraps inside it.
  assign next_addr_c = (req_addr & ~WIN_LO) | ((req_addr + 32'd4) & WIN);
  assign ld_pair_c   = {drdata, (state == ACC1) ? rbuf_q : drdata};
  assign ld_word_c   = ld_pair_c[6'({off_q, 3'b000}) +: 32];
`endif

  lsu_load_align u_align (
    .data    (ld_word_c),
    .funct3  (f3_q),
    .rdata_c (ld_rdata_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      daddr       <= 32'd0;
      dwdata      <= 32'd0;
      dwe         <= 4'd0;
      store_q     <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
`ifndef MISALIGN_TRAP_EN
      rbuf_q      <= 32'd0;
      next_addr_q <= 32'd0;
      wdata_hi_q  <= 32'd0;
      mask_hi_q   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_q   <= req_store;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            if (req_bad_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state <= ACC0;
              daddr <= {req_addr[31:2], 2'b00};
              dwe   <= req_store ? req_mask_c[3:0] : 4'd0;
              if (req_store) dwdata <= st_lo_c;
`ifndef MISALIGN_TRAP_EN
              next_addr_q <= next_addr_c;
              mask_hi_q   <= req_mask_c[7:4];
              wdata_hi_q  <= st_pair_c[63:32];
`endif
            end
          end
        end
        ACC0: begin
          dwe <= 4'd0;
`ifndef MISALIGN_TRAP_EN
          rbuf_q <= drdata;
          if (mask_hi_q != 4'd0) begin
            state <= ACC1;
            daddr <= next_addr_q;
            dwe   <= store_q ? mask_hi_q : 4'd0;
            if (store_q) dwdata <= wdata_hi_q;
          end else
`endif
          begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= store_q ? 32'd0 : ld_rdata_c;
          end
        end
`ifndef MISALIGN_TRAP_EN
        ACC1: begin
          dwe       <= 4'd0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= store_q ? 32'd0 : ld_rdata_c;
        end
`endif
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          dwe       <= 4'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a word memory model and a response scoreboard.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, daddr, dwdata, drdata;
  logic [3:0]  dwe;
  logic        mem_clr;
  logic [31:0] mem [0:4095];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  lsu_dmem_master #(.DMEM_AW(14)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign drdata = mem[daddr[13:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      mem[64] <= 32'h8899AABB;
      mem[65] <= 32'h11223344;
    end else begin
      for (int i = 0; i < 4; i++)
        if (dwe[i]) mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.rdata);
        chk({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
        chk({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic er, input int lat, input int acc,
                          input string tag);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.acc = acc; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one request, return #1 after its accept edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input int elat, input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_exp(erd, eerr, elat, cyc, tag);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] erd,
                    input string tag);
    issue(1'b0, f3, a, 32'd0, erd, 1'b0, 2, tag);
    chk({tag, "_dwe"}, 32'(dwe), 32'd0);
    wait_idle(tag);
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dwdata", dwdata, 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    reset = 1'b0; mem_clr = 1'b0;

    // Loads with extension, aligned and non-crossing unaligned
    ld(F3_B,  32'h103, 32'hFFFFFF88, "lb103");
    ld(F3_BU, 32'h103, 32'h00000088, "lbu103");
    ld(F3_H,  32'h102, 32'hFFFF8899, "lh102");
    ld(F3_H,  32'h101, 32'hFFFF99AA, "lh101");
    ld(F3_HU, 32'h101, 32'h000099AA, "lhu101");
    ld(F3_W,  32'h100, 32'h8899AABB, "lw100");

    // Word-crossing load
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 32'h103, 32'd0, 32'd0, 1'b1, 1, "lw_split");
    chk("lw_split_dwe0", 32'(dwe), 32'd0);
    @(posedge clk); #1;
    chk("lw_split_dwe1", 32'(dwe), 32'd0);
`else
    issue(1'b0, F3_W, 32'h103, 32'd0, 32'h22334488, 1'b0, 3, "lw_split");
    chk("lw_split_daddr0", daddr, 32'h100);
    chk("lw_split_dwe0", 32'(dwe), 32'd0);
    @(posedge clk); #1;
    chk("lw_split_daddr1", daddr, 32'h104);
    chk("lw_split_dwe1", 32'(dwe), 32'd0);
`endif
    wait_idle("lw_split");

    // Halfword store into upper lanes, then readback
    issue(1'b1, F3_H, 32'h102, 32'h0000CAFE, 32'd0, 1'b0, 2, "sh102");
    chk("sh102_daddr", daddr, 32'h100);
    chk("sh102_dwe", 32'(dwe), 32'hC);
    chk("sh102_dwdata", dwdata, 32'hCAFE0000);
    wait_idle("sh102");
    chk("sh102_dwe_after", 32'(dwe), 32'd0);
    ld(F3_HU, 32'h102, 32'h0000CAFE, "lhu102");
    ld(F3_W,  32'h100, 32'hCAFEAABB, "lw100b");

    // Store crossing the top of the memory window
`ifdef MISALIGN_TRAP_EN
    issue(1'b1, F3_W, 32'h3FFE, 32'hDEADBEEF, 32'd0, 1'b1, 1, "sw_wrap");
    chk("sw_wrap_dwe0", 32'(dwe), 32'd0);
    @(posedge clk); #1;
    chk("sw_wrap_dwe1", 32'(dwe), 32'd0);
    wait_idle("sw_wrap");
    ld(F3_W, 32'h3FFC, 32'h00000000, "lw3ffc");
    ld(F3_W, 32'h0000, 32'h00000000, "lw0000");
`else
    issue(1'b1, F3_W, 32'h3FFE, 32'hDEADBEEF, 32'd0, 1'b0, 3, "sw_wrap");
    chk("sw_wrap_daddr0", daddr, 32'h3FFC);
    chk("sw_wrap_dwe0", 32'(dwe), 32'hC);
    chk("sw_wrap_dwdata0", dwdata, 32'hBEEF0000);
    @(posedge clk); #1;
    chk("sw_wrap_daddr1", daddr, 32'h0000);
    chk("sw_wrap_dwe1", 32'(dwe), 32'h3);
    chk("sw_wrap_dwdata1", dwdata, 32'h0000DEAD);
    wait_idle("sw_wrap");
    ld(F3_W, 32'h3FFC, 32'hBEEF0000, "lw3ffc");
    ld(F3_W, 32'h0000, 32'h0000DEAD, "lw0000");
`endif

    // Invalid funct3 with req_valid held high into a following valid request
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd3; req_addr = 32'h100;
    @(posedge clk); #1;
    push_exp(32'd0, 1'b1, 1, cyc, "bad_f3");
    req_funct3 = F3_W; req_addr = 32'h104;
    chk("bad_f3_ready", 32'(req_ready), 32'd0);
    chk("bad_f3_dwe", 32'(dwe), 32'd0);
    @(posedge clk); #1;
    chk("bad_f3_idle_ready", 32'(req_ready), 32'd1);
    chk("bad_f3_idle_dwe", 32'(dwe), 32'd0);
    push_exp(32'h11223344, 1'b0, 2, cyc + 1, "held_lw");
    @(posedge clk); #1;
    chk("held_lw_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_idle("held_lw");

    // Store with an unsigned width code is rejected without writing
    issue(1'b1, F3_BU, 32'h200, 32'h000000FF, 32'd0, 1'b1, 1, "sbu_err");
    chk("sbu_err_dwe", 32'(dwe), 32'd0);
    wait_idle("sbu_err");
    issue(1'b0, 3'd7, 32'h100, 32'd0, 32'd0, 1'b1, 1, "f3_7");
    wait_idle("f3_7");
    ld(F3_W, 32'h200, 32'h00000000, "lw200a");

`ifndef MISALIGN_TRAP_EN
    // Reset during the second cycle of a split store
    issue(1'b1, F3_W, 32'h201, 32'h11111111, 32'd0, 1'b0, 3, "sw_rst");
    chk("sw_rst_dwe0", 32'(dwe), 32'hE);
    @(posedge clk); #1;
    chk("sw_rst_dwe1", 32'(dwe), 32'h1);
    chk("sw_rst_daddr1", daddr, 32'h204);
    #1 reset = 1'b1;
    #1 chk("sw_rst_dwe_async", 32'(dwe), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("sw_rst_ready", 32'(req_ready), 32'd1);
      chk("sw_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    ld(F3_W, 32'h200, 32'h11111100, "lw200b");
    ld(F3_W, 32'h204, 32'h00000000, "lw204");
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
